// File: rtl/drowsy_decision.sv
// drowsy_decision: registers per-frame class scores, picks the signed argmax winner,
// and debounces drowsy decisions into a latched driver alarm with hysteresis.
`default_nettype none

module drowsy_decision #(
  parameter int W            = 10,
  parameter int CLS_DROWSY   = 2,
  parameter int ALARM_THRESH = 8,
  parameter int CLEAR_THRESH = 4
) (
  input  logic         Clock,
  input  logic         Rst,
  input  logic         in_valid,
  input  logic [W-1:0] score0,
  input  logic [W-1:0] score1,
  input  logic [W-1:0] score2,
  input  logic         alarm_clr,
  output logic [1:0]   class_out,
  output logic         class_valid,
  output logic         alarm,
  output logic [1:0]   state,
  output logic [7:0]   alarm_events
);

  typedef enum logic [1:0] {
    ST_ALERT   = 2'b00,
    ST_SUSPECT = 2'b01,
    ST_ALARM   = 2'b10,
    ST_RECOVER = 2'b11
  } state_t;

  localparam logic [1:0] CLS_D   = 2'(CLS_DROWSY);
  localparam logic [7:0] ALARM_T = 8'(ALARM_THRESH);
  localparam logic [7:0] CLEAR_T = 8'(CLEAR_THRESH);

  logic [W-1:0] s0_q, s1_q, s2_q, s0_d, s1_d, s2_d;
  logic         v1_q, v1_d;
  logic [1:0]   class_out_q, class_out_d;
  logic         class_valid_q, class_valid_d;
  state_t       state_q, state_d;
  logic [7:0]   dcnt_q, dcnt_d, ccnt_q, ccnt_d;
  logic [7:0]   events_q, events_d;
  logic         alarm_q, alarm_d;

  logic [W-1:0] max01;
  logic [1:0]   idx01;
  logic         drowsy;

  // Stage 1: capture scores; the valid bit follows in_valid every cycle.
  always_comb begin
    v1_d = in_valid;
    s0_d = s0_q;
    s1_d = s1_q;
    s2_d = s2_q;
    if (in_valid) begin
      s0_d = score0;
      s1_d = score1;
      s2_d = score2;
    end
  end

  // Stage 2: signed argmax; strict greater-than keeps ties on the lowest index.
  always_comb begin
    max01 = s0_q;
    idx01 = 2'd0;
    if ($signed(s1_q) > $signed(s0_q)) begin
      max01 = s1_q;
      idx01 = 2'd1;
    end
    class_out_d   = class_out_q;
    class_valid_d = v1_q;
    if (v1_q) begin
      class_out_d = ($signed(s2_q) > $signed(max01)) ? 2'd2 : idx01;
    end
  end

  assign drowsy = (class_out_q == CLS_D);

  always_comb begin
    state_d  = state_q;
    dcnt_d   = dcnt_q;
    ccnt_d   = ccnt_q;
    events_d = events_q;
    if (alarm_clr) begin
      state_d = ST_ALERT;
      dcnt_d  = 8'd0;
      ccnt_d  = 8'd0;
    end else if (class_valid_q) begin
      case (state_q)
        ST_ALERT: begin
          if (drowsy) begin
            state_d = ST_SUSPECT;
            dcnt_d  = 8'd1;
          end
        end
        ST_SUSPECT: begin
          if (drowsy) begin
            dcnt_d = dcnt_q + 8'd1;
            if (dcnt_q + 8'd1 == ALARM_T) begin
              state_d = ST_ALARM;
              if (events_q != 8'hFF) events_d = events_q + 8'd1;
            end
          end else begin
            state_d = ST_ALERT;
            dcnt_d  = 8'd0;
          end
        end
        ST_ALARM: begin
          if (!drowsy) begin
            state_d = ST_RECOVER;
            ccnt_d  = 8'd1;
          end
        end
        ST_RECOVER: begin
          if (drowsy) begin
            state_d = ST_ALARM;
            ccnt_d  = 8'd0;
          end else begin
            ccnt_d = ccnt_q + 8'd1;
            if (ccnt_q + 8'd1 == CLEAR_T) begin
              state_d = ST_ALERT;
              dcnt_d  = 8'd0;
              ccnt_d  = 8'd0;
            end
          end
        end
        default: state_d = ST_ALERT;
      endcase
    end
    alarm_d = (state_d == ST_ALARM) || (state_d == ST_RECOVER);
  end

  always_ff @(posedge Clock) begin
    if (!Rst) begin
      s0_q          <= '0;
      s1_q          <= '0;
      s2_q          <= '0;
      v1_q          <= 1'b0;
      class_out_q   <= 2'd0;
      class_valid_q <= 1'b0;
      state_q       <= ST_ALERT;
      dcnt_q        <= 8'd0;
      ccnt_q        <= 8'd0;
      events_q      <= 8'd0;
      alarm_q       <= 1'b0;
    end else begin
      s0_q          <= s0_d;
      s1_q          <= s1_d;
      s2_q          <= s2_d;
      v1_q          <= v1_d;
      class_out_q   <= class_out_d;
      class_valid_q <= class_valid_d;
      state_q       <= state_d;
      dcnt_q        <= dcnt_d;
      ccnt_q        <= ccnt_d;
      events_q      <= events_d;
      alarm_q       <= alarm_d;
    end
  end

  assign class_out    = class_out_q;
  assign class_valid  = class_valid_q;
  assign alarm        = alarm_q;
  assign state        = state_q;
  assign alarm_events = events_q;

endmodule

`default_nettype wire

// File: tb/tb_drowsy_decision.sv
// tb_drowsy_decision: directed stimulus with a class scoreboard plus alarm/FSM checkpoints.
`default_nettype none

module tb_drowsy_decision;

  logic       Clock = 1'b0;
  logic       Rst = 1'b0;
  logic       in_valid = 1'b0;
  logic [9:0] score0 = '0, score1 = '0, score2 = '0;
  logic       alarm_clr = 1'b0;
  logic [1:0] class_out;
  logic       class_valid;
  logic       alarm;
  logic [1:0] state;
  logic [7:0] alarm_events;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int cls;
    int due;
  } exp_t;
  exp_t sb[$];

  drowsy_decision dut (
    .Clock(Clock), .Rst(Rst), .in_valid(in_valid),
    .score0(score0), .score1(score1), .score2(score2),
    .alarm_clr(alarm_clr), .class_out(class_out), .class_valid(class_valid),
    .alarm(alarm), .state(state), .alarm_events(alarm_events)
  );

  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Frame outcomes are due exactly two cycles after their in_valid cycle.
  always @(negedge Clock) begin
    if (Rst) begin
      if (sb.size() > 0 && sb[0].due <= cyc) begin
        exp_t e;
        e = sb.pop_front();
        checks++;
        assert (class_valid === 1'b1 && int'(class_out) === e.cls && e.due == cyc) else begin
          errors++;
          $error("FAIL class_frame observed valid=%0b class=%0d at %0d expected class=%0d at %0d",
                 class_valid, class_out, cyc, e.cls, e.due);
        end
      end else if (class_valid) begin
        checks++;
        errors++;
        $error("FAIL stray_valid observed class_valid=1 at %0d expected 0", cyc);
      end
    end
  end

  task automatic frame(input int s0, input int s1, input int s2, input int cls);
    @(negedge Clock);
    in_valid  = 1'b1;
    score0    = 10'(s0);
    score1    = 10'(s1);
    score2    = 10'(s2);
    if (Rst) sb.push_back('{cls: cls, due: cyc + 2});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge Clock);
      in_valid = 1'b0;
    end
  endtask

  task automatic drowsy_frames(input int n);
    for (int i = 0; i < n; i++) frame(0, 0, 100, 2);
  endtask

  task automatic alert_frames(input int n);
    for (int i = 0; i < n; i++) frame(100, 0, 0, 0);
  endtask

  task automatic pulse_clear();
    @(negedge Clock);
    in_valid  = 1'b0;
    alarm_clr = 1'b1;
    @(negedge Clock);
    alarm_clr = 1'b0;
  endtask

  initial begin
    // Reset held with live frames: nothing may come out.
    in_valid = 1'b1;
    score2   = 10'd100;
    @(posedge Clock);
    @(posedge Clock);
    @(negedge Clock);
    chk("rst_class_valid", class_valid, 0);
    chk("rst_class_out", class_out, 0);
    chk("rst_alarm", alarm, 0);
    chk("rst_state", state, 0);
    chk("rst_events", alarm_events, 0);
    Rst      = 1'b1;
    in_valid = 1'b0;
    idle(3);

    // Argmax and tie handling.
    frame(-5, 3, 3, 1);
    idle(3);
    frame(-512, -512, -511, 2);
    frame(7, -1, 7, 0);
    frame(-1, -1, -1, 0);
    frame(-100, 511, -512, 1);
    idle(4);
    chk("argmax_state", state, 0);

    // Raise after 8 consecutive drowsy frames.
    drowsy_frames(8);
    idle(2);
    chk("raise_early_alarm", alarm, 0);
    idle(1);
    chk("raise_alarm", alarm, 1);
    chk("raise_state", state, 2);
    chk("raise_events", alarm_events, 1);
    pulse_clear();
    chk("clr_alarm", alarm, 0);
    chk("clr_state", state, 0);

    // 7 drowsy then one alert frame must not raise.
    drowsy_frames(7);
    idle(3);
    chk("seven_state", state, 1);
    chk("seven_alarm", alarm, 0);
    alert_frames(1);
    idle(3);
    chk("broken_state", state, 0);
    chk("broken_alarm", alarm, 0);

    // Hysteresis through RECOVER.
    drowsy_frames(8);
    idle(3);
    chk("hyst_raise", alarm, 1);
    alert_frames(3);
    idle(3);
    chk("hyst_recover_state", state, 3);
    chk("hyst_recover_alarm", alarm, 1);
    drowsy_frames(1);
    idle(3);
    chk("hyst_back_state", state, 2);
    alert_frames(3);
    idle(3);
    chk("hyst_3clear_state", state, 3);
    chk("hyst_3clear_alarm", alarm, 1);
    alert_frames(1);
    idle(3);
    chk("hyst_drop_state", state, 0);
    chk("hyst_drop_alarm", alarm, 0);
    chk("hyst_events", alarm_events, 2);

    // Clear coinciding with the 8th drowsy frame's class_valid.
    drowsy_frames(8);
    idle(1);
    @(negedge Clock);
    alarm_clr = 1'b1;
    @(negedge Clock);
    alarm_clr = 1'b0;
    chk("prio_alarm", alarm, 0);
    chk("prio_state", state, 0);
    chk("prio_events", alarm_events, 2);
    drowsy_frames(7);
    idle(3);
    chk("prio_seven_alarm", alarm, 0);
    drowsy_frames(1);
    idle(3);
    chk("prio_raise_alarm", alarm, 1);
    chk("prio_raise_events", alarm_events, 3);
    pulse_clear();

    // Saturate the raise counter.
    for (int r = 0; r < 300; r++) begin
      drowsy_frames(8);
      idle(3);
      pulse_clear();
    end
    chk("sat_events", alarm_events, 255);

    // Reset with frames in flight discards them.
    frame(0, 100, 0, 1);
    @(negedge Clock);
    Rst      = 1'b0;
    in_valid = 1'b1;
    sb.delete();
    idle(2);
    Rst = 1'b1;
    idle(6);
    chk("midrst_events", alarm_events, 0);
    chk("midrst_state", state, 0);
    chk("midrst_class_out", class_out, 0);
    chk("sb_drain", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
